// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue stage.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESULT
    } div_state_t;

    // Wide all-ones pattern; users slice it down to their operand width.
    localparam logic [63:0] DIV_DZ_QUOTIENT = '1;
    localparam int unsigned DIV_MAX_SETTLE = 15;

endpackage

// File: rtl/div_issue_stage.sv
// Registers operands for an external combinational divider, waits a settle time and holds the result.
// Optional macro DIV_ISSUE_STATS_EN adds retired-op and divide-by-zero counters.
module div_issue_stage
    import div_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_dz,
`ifdef DIV_ISSUE_STATS_EN
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_dz,
`endif
    output logic             busy
);

    generate
        if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > DIV_MAX_SETTLE)) begin : g_bad_settle
            $error("div_issue_stage: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [WIDTH-1:0] DzQuotient = DIV_DZ_QUOTIENT[WIDTH-1:0];
    localparam logic [3:0]       CntInit    = 4'(SETTLE_CYCLES - 1);

    div_state_t       state_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] div_a_q;
    logic [WIDTH-1:0] div_b_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dz_q;
    logic             valid_q;

    logic accept;
    logic retire;

    assign in_ready = (state_q == IDLE) || ((state_q == RESULT) && out_ready);
    assign accept   = in_valid && in_ready;
    assign retire   = (state_q == RESULT) && out_ready;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_a_q <= '0;
            div_b_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            valid_q <= 1'b0;
        end else if (accept) begin
            // Covers both a fresh accept from IDLE and a back-to-back accept on retire.
            div_a_q <= in_a;
            div_b_q <= in_b;
            if (in_b == '0) begin
                state_q <= RESULT;
                quot_q  <= DzQuotient;
                rem_q   <= in_a;
                dz_q    <= 1'b1;
                valid_q <= 1'b1;
            end else begin
                state_q <= SETTLE;
                cnt_q   <= CntInit;
                dz_q    <= 1'b0;
                valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                SETTLE: begin
                    if (cnt_q == '0) begin
                        quot_q  <= div_quotient;
                        rem_q   <= div_remainder;
                        valid_q <= 1'b1;
                        state_q <= RESULT;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ISSUE_STATS_EN
    logic [15:0] stat_ops_q;
    logic [15:0] stat_dz_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stat_ops_q <= '0;
            stat_dz_q  <= '0;
        end else if (retire) begin
            stat_ops_q <= stat_ops_q + 16'd1;
            if (dz_q) begin
                stat_dz_q <= stat_dz_q + 16'd1;
            end
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_dz  = stat_dz_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    assign div_a         = div_a_q;
    assign div_b         = div_b_q;
    assign out_valid     = valid_q;
    assign out_quotient  = quot_q;
    assign out_remainder = rem_q;
    assign out_dz        = dz_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_div_issue_stage.sv
// Directed bench for div_issue_stage: one instance with SETTLE_CYCLES=1 and one with 3.
module tb_div_issue_stage;

    logic clk = 1'b0;
    logic arst;

    always #5 clk = ~clk;

    // Instance 1: SETTLE_CYCLES = 1
    logic       iv1, ir1, ov1, or1, odz1, busy1;
    logic [3:0] ia1, ib1, da1, db1, dq1, dr1, oq1, orm1;
    // Instance 3: SETTLE_CYCLES = 3
    logic       iv3, ir3, ov3, or3, odz3, busy3;
    logic [3:0] ia3, ib3, da3, db3, dq3, dr3, oq3, orm3;
`ifdef DIV_ISSUE_STATS_EN
    logic [15:0] sops1, sdz1, sops3, sdz3;
`endif

    // Stand-in for the external combinational divider.
    always_comb begin
        dq1 = 4'd0;
        dr1 = 4'd0;
        dq3 = 4'd0;
        dr3 = 4'd0;
        if (db1 != 4'd0) begin
            dq1 = da1 / db1;
            dr1 = da1 % db1;
        end
        if (db3 != 4'd0) begin
            dq3 = da3 / db3;
            dr3 = da3 % db3;
        end
    end

    div_issue_stage #(.WIDTH(4), .SETTLE_CYCLES(1)) u_dut1 (
        .clk          (clk),
        .arst         (arst),
        .in_valid     (iv1),
        .in_ready     (ir1),
        .in_a         (ia1),
        .in_b         (ib1),
        .div_a        (da1),
        .div_b        (db1),
        .div_quotient (dq1),
        .div_remainder(dr1),
        .out_valid    (ov1),
        .out_ready    (or1),
        .out_quotient (oq1),
        .out_remainder(orm1),
        .out_dz       (odz1),
`ifdef DIV_ISSUE_STATS_EN
        .stat_ops     (sops1),
        .stat_dz      (sdz1),
`endif
        .busy         (busy1)
    );

    div_issue_stage #(.WIDTH(4), .SETTLE_CYCLES(3)) u_dut3 (
        .clk          (clk),
        .arst         (arst),
        .in_valid     (iv3),
        .in_ready     (ir3),
        .in_a         (ia3),
        .in_b         (ib3),
        .div_a        (da3),
        .div_b        (db3),
        .div_quotient (dq3),
        .div_remainder(dr3),
        .out_valid    (ov3),
        .out_ready    (or3),
        .out_quotient (oq3),
        .out_remainder(orm3),
        .out_dz       (odz3),
`ifdef DIV_ISSUE_STATS_EN
        .stat_ops     (sops3),
        .stat_dz      (sdz3),
`endif
        .busy         (busy3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on instance 1 with out_ready high; bounded wait for the result.
    task automatic do_op1(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er, input logic edz);
        iv1 = 1'b1;
        ia1 = a;
        ib1 = b;
        or1 = 1'b1;
        tick();
        iv1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ov1) break;
            tick();
        end
        check_eq("op_valid", 32'(ov1), 32'd1);
        check_eq("op_quot", 32'(oq1), 32'(eq));
        check_eq("op_rem", 32'(orm1), 32'(er));
        check_eq("op_dz", 32'(odz1), 32'(edz));
        tick();
        check_eq("op_retired", 32'(ov1), 32'd0);
    endtask

    initial begin
        arst = 1'b1;
        iv1 = 1'b0; ia1 = '0; ib1 = '0; or1 = 1'b0;
        iv3 = 1'b0; ia3 = '0; ib3 = '0; or3 = 1'b0;
        #12;
        check_eq("rst_valid", 32'(ov1), 32'd0);
        check_eq("rst_busy", 32'(busy1), 32'd0);
        check_eq("rst_div_a", 32'(da1), 32'd0);
        check_eq("rst_quot", 32'(oq1), 32'd0);
        check_eq("rst_dz", 32'(odz1), 32'd0);
        check_eq("rst_in_ready", 32'(ir1), 32'd1);
        arst = 1'b0;
        tick();

        // SETTLE_CYCLES=1: 13/3 -> 4 r1, one cycle after accept
        iv1 = 1'b1; ia1 = 4'd13; ib1 = 4'd3; or1 = 1'b1;
        tick();
        iv1 = 1'b0;
        check_eq("s1_valid_n", 32'(ov1), 32'd0);
        check_eq("s1_busy_n", 32'(busy1), 32'd1);
        check_eq("s1_div_a", 32'(da1), 32'd13);
        check_eq("s1_div_b", 32'(db1), 32'd3);
        check_eq("s1_in_ready_settle", 32'(ir1), 32'd0);
        tick();
        check_eq("s1_valid", 32'(ov1), 32'd1);
        check_eq("s1_quot", 32'(oq1), 32'd4);
        check_eq("s1_rem", 32'(orm1), 32'd1);
        check_eq("s1_dz", 32'(odz1), 32'd0);
        check_eq("s1_in_ready_result", 32'(ir1), 32'd1);
        tick();
        check_eq("s1_retire_valid", 32'(ov1), 32'd0);
        check_eq("s1_retire_busy", 32'(busy1), 32'd0);

        // Divide by zero: 7/0 -> 15 r7, dz, one cycle
        iv1 = 1'b1; ia1 = 4'd7; ib1 = 4'd0;
        tick();
        iv1 = 1'b0;
        check_eq("dz_valid", 32'(ov1), 32'd1);
        check_eq("dz_quot", 32'(oq1), 32'd15);
        check_eq("dz_rem", 32'(orm1), 32'd7);
        check_eq("dz_flag", 32'(odz1), 32'd1);
        tick();
        check_eq("dz_retire", 32'(ov1), 32'd0);

        // Backpressure: 15/4 -> 3 r3 held for 5 cycles; pending request must not be taken
        or1 = 1'b0; iv1 = 1'b1; ia1 = 4'd15; ib1 = 4'd4;
        tick();
        ia1 = 4'd1; ib1 = 4'd1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", 32'(ov1), 32'd1);
            check_eq("bp_quot", 32'(oq1), 32'd3);
            check_eq("bp_rem", 32'(orm1), 32'd3);
            check_eq("bp_in_ready", 32'(ir1), 32'd0);
            check_eq("bp_div_a", 32'(da1), 32'd15);
            tick();
        end
        iv1 = 1'b0; or1 = 1'b1;
        tick();
        check_eq("bp_retire_valid", 32'(ov1), 32'd0);
        check_eq("bp_retire_busy", 32'(busy1), 32'd0);

        // Back-to-back with SETTLE_CYCLES=3: (8,3) then (15,1)
        iv3 = 1'b1; ia3 = 4'd8; ib3 = 4'd3; or3 = 1'b1;
        tick();
        ia3 = 4'd15; ib3 = 4'd1;
        check_eq("b2b_div_a0", 32'(da3), 32'd8);
        tick();
        check_eq("b2b_valid_n1", 32'(ov3), 32'd0);
        tick();
        check_eq("b2b_valid_n2", 32'(ov3), 32'd0);
        tick();
        check_eq("b2b_valid_n3", 32'(ov3), 32'd1);
        check_eq("b2b_quot0", 32'(oq3), 32'd2);
        check_eq("b2b_rem0", 32'(orm3), 32'd2);
        check_eq("b2b_in_ready", 32'(ir3), 32'd1);
        tick();
        iv3 = 1'b0;
        check_eq("b2b_valid_m0", 32'(ov3), 32'd0);
        check_eq("b2b_busy_m0", 32'(busy3), 32'd1);
        check_eq("b2b_div_a1", 32'(da3), 32'd15);
        check_eq("b2b_div_b1", 32'(db3), 32'd1);
        tick();
        check_eq("b2b_valid_m1", 32'(ov3), 32'd0);
        tick();
        check_eq("b2b_valid_m2", 32'(ov3), 32'd0);
        tick();
        check_eq("b2b_valid_m3", 32'(ov3), 32'd1);
        check_eq("b2b_quot1", 32'(oq3), 32'd15);
        check_eq("b2b_rem1", 32'(orm3), 32'd0);
        check_eq("b2b_dz1", 32'(odz3), 32'd0);
        tick();
        check_eq("b2b_retire", 32'(ov3), 32'd0);

        // Reset mid-operation: dut3 in SETTLE with 9/2, dut1 holding a dz result
        iv3 = 1'b1; ia3 = 4'd9; ib3 = 4'd2;
        iv1 = 1'b1; ia1 = 4'd5; ib1 = 4'd0; or1 = 1'b0;
        tick();
        iv3 = 1'b0; iv1 = 1'b0;
        check_eq("mid_busy3_pre", 32'(busy3), 32'd1);
        check_eq("mid_valid1_pre", 32'(ov1), 32'd1);
        arst = 1'b1;
        #1;
        check_eq("mid_valid3", 32'(ov3), 32'd0);
        check_eq("mid_busy3", 32'(busy3), 32'd0);
        check_eq("mid_div_a3", 32'(da3), 32'd0);
        check_eq("mid_valid1", 32'(ov1), 32'd0);
        check_eq("mid_quot1", 32'(oq1), 32'd0);
        check_eq("mid_dz1", 32'(odz1), 32'd0);
        #3;
        arst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("mid_no_result", 32'(ov3), 32'd0);
            check_eq("mid_idle", 32'(busy3), 32'd0);
        end

        // Mixed ops on dut1: three normal, two divide-by-zero
        do_op1(4'd10, 4'd3, 4'd3, 4'd1, 1'b0);
        do_op1(4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
        do_op1(4'd2, 4'd5, 4'd0, 4'd2, 1'b0);
        do_op1(4'd0, 4'd0, 4'd15, 4'd0, 1'b1);
        do_op1(4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
`ifdef DIV_ISSUE_STATS_EN
        check_eq("stat_ops", 32'(sops1), 32'd5);
        check_eq("stat_dz", 32'(sdz1), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
